ram_responder: RTL and testbench

Synthesizable memory-side responder for the CPU doubleword RAM port. Port names match the CPU's ram_* bundle so the two connect name-for-name. It accepts read and byte-masked write requests and replies through the ram_ready handshake. Backing store is an internal synchronous single-port array. Byte-masked writes are done as read-modify-write.

---
 rtl/ram_responder.sv | 131 +++++++++++++
 tb/tb_ram_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - doubleword RAM responder: reads and byte-masked read-modify-write writes
// One access in flight at a time; ram_ready low while busy, optional wait states before each access.
module ram_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] ram_addr,
  input  logic [63:0] ram_dout,
  input  logic [7:0]  ram_mask,
  input  logic        ram_re,
  input  logic        ram_we,
  output logic [63:0] ram_din,
  output logic        ram_ready,
  output logic        ram_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [28:0] DEPTH_W = 29'(DEPTH);
  localparam logic [3:0]  WS      = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WR_FETCH,
    S_WR_COMMIT
  } state_t;

  state_t      state, state_d;
  logic [3:0]  wait_cnt, wait_cnt_d;
  logic        ready_d, err_d;
  logic        accept;
  logic [27:0] addr_q;
  logic [63:0] data_q;
  logic [7:0]  mask_q;
  logic        is_write_q;
  logic [63:0] merge_q, merged;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [63:0] mem [DEPTH];

  assign accept   = ram_ready && (ram_re || ram_we);
  // Full 28-bit compare: high address bits must not alias onto the array.
  assign in_range = {1'b0, addr_q} < DEPTH_W;
  assign idx      = addr_q[AW-1:0];

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    ready_d    = ram_ready;
    err_d      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          ready_d = 1'b0;
          if (WS != 4'd0) begin
            state_d    = S_WAIT;
            wait_cnt_d = WS;
          end else begin
            state_d = ram_re ? S_READ : S_WR_FETCH;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = (wait_cnt <= 4'd1) ? 4'd0 : wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_d = is_write_q ? S_WR_FETCH : S_READ;
      end
      S_READ: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        err_d   = !in_range;
      end
      S_WR_FETCH: begin
        state_d = S_WR_COMMIT;
      end
      S_WR_COMMIT: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        err_d   = !in_range;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      ram_ready <= 1'b1;
      ram_err   <= 1'b0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_cnt_d;
      ram_ready <= ready_d;
      ram_err   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q     <= ram_addr;
      data_q     <= ram_dout;
      mask_q     <= ram_mask;
      is_write_q <= !ram_re;
    end
    if (state == S_WR_FETCH) merge_q <= mem[idx];
  end

  always_comb begin
    merged = merge_q;
    for (int j = 0; j < 8; j++) begin
      if (mask_q[j]) merged[8*j +: 8] = data_q[8*j +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ram_din <= '0;
    else if (state == S_READ) ram_din <= in_range ? mem[idx] : '0;
  end

  // Reset wins over a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && state == S_WR_COMMIT && in_range) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder
// Two instances: index 0 with no wait states, index 1 with three.
module tb_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [27:0] addr  [2];
  logic [63:0] wdata [2];
  logic [7:0]  mask  [2];
  logic        re    [2];
  logic        we    [2];
  logic [63:0] din   [2];
  logic        ready [2];
  logic        err   [2];

  ram_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .ram_addr(addr[0]), .ram_dout(wdata[0]), .ram_mask(mask[0]),
    .ram_re(re[0]), .ram_we(we[0]), .ram_din(din[0]), .ram_ready(ready[0]), .ram_err(err[0])
  );

  ram_responder #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst), .ram_addr(addr[1]), .ram_dout(wdata[1]), .ram_mask(mask[1]),
    .ram_re(re[1]), .ram_we(we[1]), .ram_din(din[1]), .ram_ready(ready[1]), .ram_err(err[1])
  );

  typedef struct {
    logic [63:0] din;
    logic        err;
    int          busy;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       obs;
  resp_t       e;
  logic        obs_err_next;
  logic [63:0] model [2][0:255];
  logic [63:0] last_din [2];
  int          checks = 0;
  int          failures = 0;

  // Drives one request at the current negedge, records the expected response in
  // the scoreboard, and captures the observed response when ready returns.
  task automatic issue(input int sel, input logic r, input logic w, input logic [27:0] a,
                       input logic [63:0] d, input logic [7:0] m,
                       input bit noise, input logic [27:0] na, input bit settle);
    resp_t       ex;
    int          ws;
    int          busy;
    bit          done;
    logic [63:0] old;
    ws = (sel == 1) ? 3 : 0;
    ex.err = (a >= 28'd256);
    if (r) begin
      ex.din = ex.err ? 64'h0 : model[sel][a[7:0]];
      last_din[sel] = ex.din;
      ex.busy = 1 + ws;
    end else begin
      if (!ex.err) begin
        old = model[sel][a[7:0]];
        for (int j = 0; j < 8; j++) if (m[j]) old[8*j +: 8] = d[8*j +: 8];
        model[sel][a[7:0]] = old;
      end
      ex.din = last_din[sel];
      ex.busy = 2 + ws;
    end
    exp_q.push_back(ex);
    re[sel] = r; we[sel] = w; addr[sel] = a; wdata[sel] = d; mask[sel] = m;
    @(posedge clk);
    #1;
    re[sel] = 1'b0; we[sel] = 1'b0;
    addr[sel] = 28'($urandom); wdata[sel] = {$urandom, $urandom}; mask[sel] = 8'($urandom);
    busy = 0;
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready[sel]) begin
        re[sel] = 1'b0; we[sel] = 1'b0;
        done = 1'b1;
        break;
      end
      busy++;
      if (noise) begin
        re[sel] = k[0]; we[sel] = !k[0];
        addr[sel] = na; wdata[sel] = '1; mask[sel] = 8'hFF;
      end
    end
    obs.din = din[sel];
    obs.err = err[sel];
    obs.busy = done ? busy : -1;
    obs_err_next = 1'b0;
    if (settle) begin
      @(negedge clk);
      obs_err_next = err[sel];
    end
  endtask

  task automatic preload(input int sel, input logic [27:0] a, input logic [63:0] d);
    issue(sel, 1'b0, 1'b1, a, d, 8'hFF, 1'b0, 28'd0, 1'b0);
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++; if (ready[s] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got %b exp 1", s, ready[s]); end
      checks++; if (din[s] !== 64'h0) begin failures++; $display("FAIL reset_din[%0d] got %h exp 0", s, din[s]); end
      checks++; if (err[s] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got %b exp 0", s, err[s]); end
      last_din[s] = 64'h0;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    preload(0, 28'd5, 64'h0123_4567_89AB_CDEF);
    issue(0, 1'b1, 1'b0, 28'd5, 64'h0, 8'h00, 1'b0, 28'd0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL read5_din got %h exp %h", obs.din, e.din); end
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL read5_busy got %0d exp %0d", obs.busy, e.busy); end
    checks++; if (obs.err !== e.err) begin failures++; $display("FAIL read5_err got %b exp %b", obs.err, e.err); end
  endtask

  task automatic test_masked_write();
    preload(0, 28'd7, 64'h1111_1111_1111_1111);
    issue(0, 1'b0, 1'b1, 28'd7, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL mwrite_busy got %0d exp %0d", obs.busy, e.busy); end
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL mwrite_din_hold got %h exp %h", obs.din, e.din); end
    issue(0, 1'b1, 1'b0, 28'd7, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== 64'h1111_1111_CCCC_DDDD) begin failures++; $display("FAIL mwrite_read7 got %h exp %h", obs.din, 64'h1111_1111_CCCC_DDDD); end
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL mwrite_model got %h exp %h", obs.din, e.din); end
  endtask

  task automatic test_both_high();
    preload(0, 28'd3, 64'h3333_3333_3333_3333);
    issue(0, 1'b1, 1'b1, 28'd3, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL both_busy got %0d exp %0d", obs.busy, e.busy); end
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL both_din got %h exp %h", obs.din, e.din); end
    issue(0, 1'b1, 1'b0, 28'd3, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL both_mem3 got %h exp %h", obs.din, e.din); end
  endtask

  task automatic test_wait_states();
    preload(1, 28'd20, 64'h2020_2020_2020_2020);
    preload(1, 28'd11, 64'h0B0B_0B0B_0B0B_0B0B);
    issue(1, 1'b1, 1'b0, 28'd11, 64'h0, 8'h00, 1'b1, 28'd20, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL ws_read_busy got %0d exp %0d", obs.busy, e.busy); end
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL ws_read_din got %h exp %h", obs.din, e.din); end
    issue(1, 1'b0, 1'b1, 28'd11, 64'h5566_7788_99AA_BBCC, 8'hF0, 1'b1, 28'd20, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL ws_write_busy got %0d exp %0d", obs.busy, e.busy); end
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL ws_write_din_hold got %h exp %h", obs.din, e.din); end
    issue(1, 1'b1, 1'b0, 28'd20, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL ws_noise_mem20 got %h exp %h", obs.din, e.din); end
    issue(1, 1'b1, 1'b0, 28'd11, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL ws_merged_mem11 got %h exp %h", obs.din, e.din); end
  endtask

  task automatic test_out_of_range();
    preload(0, 28'd44, 64'h4444_4444_4444_4444);
    issue(0, 1'b1, 1'b0, 28'h0000100, 64'h0, 8'h00, 1'b0, 28'd0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL oor_read_din got %h exp %h", obs.din, e.din); end
    checks++; if (obs.err !== e.err) begin failures++; $display("FAIL oor_read_err got %b exp %b", obs.err, e.err); end
    checks++; if (obs_err_next !== 1'b0) begin failures++; $display("FAIL oor_read_err_width got %b exp 0", obs_err_next); end
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL oor_read_busy got %0d exp %0d", obs.busy, e.busy); end
    issue(0, 1'b0, 1'b1, 28'd300, 64'hFFFF_0000_FFFF_0000, 8'hFF, 1'b0, 28'd0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (obs.err !== e.err) begin failures++; $display("FAIL oor_write_err got %b exp %b", obs.err, e.err); end
    checks++; if (obs_err_next !== 1'b0) begin failures++; $display("FAIL oor_write_err_width got %b exp 0", obs_err_next); end
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL oor_write_busy got %0d exp %0d", obs.busy, e.busy); end
    issue(0, 1'b1, 1'b0, 28'd44, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL oor_alias_mem44 got %h exp %h", obs.din, e.din); end
    checks++; if (obs.err !== e.err) begin failures++; $display("FAIL oor_inrange_err got %b exp %b", obs.err, e.err); end
    issue(0, 1'b1, 1'b0, 28'h8000005, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL oor_high_din got %h exp %h", obs.din, e.din); end
    checks++; if (obs.err !== e.err) begin failures++; $display("FAIL oor_high_err got %b exp %b", obs.err, e.err); end
  endtask

  task automatic test_back_to_back();
    preload(0, 28'd50, 64'h5050_5050_5050_5050);
    preload(0, 28'd51, 64'h5151_5151_5151_5151);
    issue(0, 1'b0, 1'b1, 28'd50, 64'h0000_0000_0000_ABCD, 8'h03, 1'b0, 28'd0, 1'b0);
    issue(0, 1'b1, 1'b0, 28'd50, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL b2b_read50 got %h exp %h", obs.din, e.din); end
    checks++; if (obs.busy != e.busy) begin failures++; $display("FAIL b2b_busy got %0d exp %0d", obs.busy, e.busy); end
    issue(0, 1'b1, 1'b0, 28'd51, 64'h0, 8'h00, 1'b0, 28'd0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL b2b_read51 got %h exp %h", obs.din, e.din); end
  endtask

  task automatic test_reset_mid();
    preload(0, 28'd9, 64'h0);
    // Abort in WR_FETCH.
    we[0] = 1'b1; addr[0] = 28'd9; wdata[0] = '1; mask[0] = 8'hFF;
    @(posedge clk); #1;
    we[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    last_din[0] = 64'h0;
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL rstfetch_ready got %b exp 1", ready[0]); end
    checks++; if (din[0] !== 64'h0) begin failures++; $display("FAIL rstfetch_din got %h exp 0", din[0]); end
    issue(0, 1'b1, 1'b0, 28'd9, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL rstfetch_mem9 got %h exp %h", obs.din, e.din); end
    // Abort with reset on the commit edge.
    preload(0, 28'd9, 64'h0909_0909_0909_0909);
    issue(0, 1'b1, 1'b0, 28'd9, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    void'(exp_q.pop_front());
    we[0] = 1'b1; addr[0] = 28'd9; wdata[0] = '1; mask[0] = 8'hFF;
    @(posedge clk); #1;
    we[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    last_din[0] = 64'h0;
    checks++; if (din[0] !== 64'h0) begin failures++; $display("FAIL rstcommit_din got %h exp 0", din[0]); end
    issue(0, 1'b1, 1'b0, 28'd9, 64'h0, 8'h00, 1'b0, 28'd0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (obs.din !== e.din) begin failures++; $display("FAIL rstcommit_mem9 got %h exp %h", obs.din, e.din); end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      addr[s] = '0; wdata[s] = '0; mask[s] = '0; re[s] = 1'b0; we[s] = 1'b0;
    end
    test_reset();
    test_read();
    test_masked_write();
    test_both_high();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
